// File: rtl/fmap_ii_pkg.sv
// Shared types and constants for the feature-map-II buffer sequencer.
package fmap_ii_pkg;

  localparam int FMAP_II_NBANK  = 144;
  localparam int FMAP_II_DEPTH  = 8;
  localparam int FMAP_II_ADDR_W = 3;

  typedef logic [FMAP_II_ADDR_W-1:0] fmap_ii_ch_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } fmap_ii_state_t;

endpackage

// File: rtl/fmap_ii_ctrl_if.sv
// Producer/consumer handshake bundle of the feature-map-II sequencer.
// master = the sequencer, slave = the producer/consumer side.
interface fmap_ii_ctrl_if
  import fmap_ii_pkg::*;
#(
  parameter int ADDR_WIDTH = FMAP_II_ADDR_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_ch;
  logic                  out_last;

  modport master (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_ch,
    output out_last
  );

  modport slave (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_ch,
    input  out_last
  );

endinterface

// File: rtl/fmap_ii_ctrl.sv
// Fill/drain sequencer for the 144-bank feature-map-II buffer (1-cycle registered SRAM reads).
// Optional macro FMAP_II_CTRL_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module fmap_ii_ctrl
  import fmap_ii_pkg::*;
#(
  parameter int ADDR_WIDTH = FMAP_II_ADDR_W,
  parameter int DEPTH      = FMAP_II_DEPTH,
  parameter int NBANK      = FMAP_II_NBANK
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  fmap_ii_ctrl_if.master        hs,
  output logic [NBANK-1:0]      fmap_wr_en,
  output logic [ADDR_WIDTH-1:0] fmap_wr_addr,
  output logic [ADDR_WIDTH-1:0] fmap_rd_addr,
  output logic                  busy,
  output logic                  done
`ifdef FMAP_II_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  // Counters carry one extra bit so that rd_cnt == DEPTH is representable.
  localparam int                    CNT_W     = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_CH   = ADDR_WIDTH'(DEPTH - 1);

  fmap_ii_state_t        state;
  fmap_ii_state_t        state_nxt;
  logic [CNT_W-1:0]      wr_cnt;
  logic [CNT_W-1:0]      rd_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] out_ch;
  logic                  out_valid;
  logic                  wr_fire;
  logic                  last_wr;
  logic                  issue;
  logic                  accept;
  logic                  last_acc;
  logic                  start_acc;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign start_acc = (state == IDLE) && start;
  assign wr_fire   = (state == FILL) && hs.in_valid;
  assign last_wr   = wr_fire && (wr_cnt == LAST_CNT);
  assign accept    = out_valid && hs.out_ready;
  assign last_acc  = accept && (out_ch == LAST_CH);
  // A new read may replace the presented channel only once it has been taken.
  assign issue     = (state == DRAIN) && (!out_valid || hs.out_ready) && (rd_cnt < DEPTH_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = FILL;
      FILL:    if (last_wr)  state_nxt = DRAIN;
      DRAIN:   if (last_acc) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hs.in_ready = (state == FILL);
    busy        = (state != IDLE);
    fmap_wr_en  = wr_fire ? {NBANK{1'b1}} : {NBANK{1'b0}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      rd_addr   <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_acc) wr_cnt <= '0;
      if (wr_fire)   wr_cnt <= wr_cnt + CNT_W'(1);
      if (last_wr)   rd_cnt <= '0;
      // Address and presented channel move together so a stall re-reads the same word.
      if (issue) begin
        rd_addr   <= rd_cnt[ADDR_WIDTH-1:0];
        out_ch    <= rd_cnt[ADDR_WIDTH-1:0];
        out_valid <= 1'b1;
        rd_cnt    <= rd_cnt + CNT_W'(1);
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (last_acc) begin
        done    <= 1'b1;
        rd_addr <= '0;
      end
    end
  end

`ifdef FMAP_II_CTRL_STALL_CNT_EN
  logic stall_ev;
  assign stall_ev = (out_valid && !hs.out_ready) || ((state == FILL) && !hs.in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        stall_cnt <= '0;
    else if (start_acc) stall_cnt <= '0;
    else if (stall_ev)  stall_cnt <= sat_inc16(stall_cnt);
  end
`endif

  assign fmap_wr_addr = wr_cnt[ADDR_WIDTH-1:0];
  assign fmap_rd_addr = rd_addr;
  assign hs.out_valid = out_valid;
  assign hs.out_ch    = out_ch;
  assign hs.out_last  = out_valid && (out_ch == LAST_CH);

endmodule

// File: tb/tb_fmap_ii_ctrl.sv
// Directed bench for fmap_ii_ctrl with a small registered-SRAM model of banks 0, 5 and 143.
module tb_fmap_ii_ctrl;
  import fmap_ii_pkg::*;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int NBANK = 144;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [NBANK-1:0] fmap_wr_en;
  logic [AW-1:0]    fmap_wr_addr;
  logic [AW-1:0]    fmap_rd_addr;
  logic             busy;
  logic             done;
`ifdef FMAP_II_CTRL_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  fmap_ii_ctrl_if #(.ADDR_WIDTH(AW)) hs ();

  fmap_ii_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .NBANK(NBANK)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .hs           (hs),
    .fmap_wr_en   (fmap_wr_en),
    .fmap_wr_addr (fmap_wr_addr),
    .fmap_rd_addr (fmap_rd_addr),
    .busy         (busy),
    .done         (done)
`ifdef FMAP_II_CTRL_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Buffer model: bank q stores q*8 + plane number of the write.
  logic [15:0] mem [3][DEPTH];
  logic [15:0] rdq [3];
  int          plane = 0;

  function automatic int bank_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 5 : NBANK - 1;
  endfunction

  always @(posedge clk) begin
    if (start && !busy) plane <= 0;
    else if (hs.in_valid && hs.in_ready) plane <= plane + 1;
    for (int i = 0; i < 3; i++) begin
      if (fmap_wr_en[bank_of(i)]) mem[i][fmap_wr_addr] <= 16'(bank_of(i) * 8 + plane);
      rdq[i] <= mem[i][fmap_rd_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_idle busy=%b expected 0", busy);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic run_fill(input logic [31:0] vpat, input int start_at);
    int wr  = 0;
    int cyc = 0;
    while (wr < DEPTH && cyc < 32) begin
      hs.in_valid = vpat[cyc];
      start       = (wr == start_at) && vpat[cyc];
      @(negedge clk);
      checks++;
      if (hs.in_ready !== 1'b1 || busy !== 1'b1 || hs.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL fill_state wr=%0d in_ready=%b busy=%b out_valid=%b expected 1 1 0",
                 wr, hs.in_ready, busy, hs.out_valid);
      end
      checks++;
      if (fmap_wr_en !== (vpat[cyc] ? {NBANK{1'b1}} : {NBANK{1'b0}})) begin
        failures++;
        $display("FAIL fill_wr_en cyc=%0d wr_en=%h in_valid=%b", cyc, fmap_wr_en, vpat[cyc]);
      end
      if (vpat[cyc]) begin
        checks++;
        if (fmap_wr_addr !== AW'(wr)) begin
          failures++;
          $display("FAIL fill_wr_addr got=%0d expected=%0d", fmap_wr_addr, wr);
        end
      end
      tick();
      if (vpat[cyc]) wr++;
      cyc++;
    end
    hs.in_valid = 1'b0;
    start       = 1'b0;
  endtask

  // Returns early (at the negedge of the presented abort_ch) when abort_ch >= 0.
  task automatic run_drain(input int stall_ch, input int stall_len, input int start_ch,
                           input int abort_ch);
    int   ch   = 0;
    int   held = 0;
    int   cyc  = 0;
    logic rdy;
    hs.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (hs.out_valid !== 1'b0 || hs.in_ready !== 1'b0 || busy !== 1'b1 || fmap_wr_en !== '0) begin
      failures++;
      $display("FAIL drain_entry out_valid=%b in_ready=%b busy=%b expected 0 0 1",
               hs.out_valid, hs.in_ready, busy);
    end
    tick();
    while (ch < DEPTH && cyc < 64) begin
      rdy          = !(ch == stall_ch && held < stall_len);
      hs.out_ready = rdy;
      start        = (ch == start_ch) && (held == 0);
      @(negedge clk);
      checks++;
      if (hs.out_valid !== 1'b1 || hs.out_ch !== AW'(ch) || fmap_rd_addr !== AW'(ch)) begin
        failures++;
        $display("FAIL drain_ch out_valid=%b out_ch=%0d rd_addr=%0d expected 1 ch=%0d",
                 hs.out_valid, hs.out_ch, fmap_rd_addr, ch);
      end
      checks++;
      if (hs.out_last !== (ch == DEPTH - 1) || done !== 1'b0) begin
        failures++;
        $display("FAIL drain_last ch=%0d out_last=%b done=%b", ch, hs.out_last, done);
      end
      if (held >= 1) begin
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (rdq[i] !== 16'(bank_of(i) * 8 + ch)) begin
            failures++;
            $display("FAIL drain_data bank=%0d got=%0d expected=%0d", bank_of(i), rdq[i],
                     bank_of(i) * 8 + ch);
          end
        end
      end
      if (ch == abort_ch) begin
        start = 1'b0;
        return;
      end
      tick();
      start = 1'b0;
      if (rdy) begin
        ch++;
        held = 0;
      end else begin
        held++;
      end
      cyc++;
    end
    hs.out_ready = 1'b1;
    if (ch != DEPTH) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout channels=%0d expected=%0d", ch, DEPTH);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || hs.out_valid !== 1'b0 || fmap_rd_addr !== '0) begin
      failures++;
      $display("FAIL drain_done done=%b busy=%b out_valid=%b rd_addr=%0d expected 1 0 0 0",
               done, busy, hs.out_valid, fmap_rd_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse done=%b expected 0", done);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    hs.in_valid  = 1'b0;
    hs.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, hs.in_ready, hs.out_valid, hs.out_last} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b done=%b in_ready=%b out_valid=%b out_last=%b expected 0",
               busy, done, hs.in_ready, hs.out_valid, hs.out_last);
    end
    checks++;
    if (fmap_wr_en !== '0 || {fmap_wr_addr, fmap_rd_addr, hs.out_ch} !== 9'd0) begin
      failures++;
      $display("FAIL reset_addr wr_en=%h wr_addr=%0d rd_addr=%0d out_ch=%0d expected 0",
               fmap_wr_en, fmap_wr_addr, fmap_rd_addr, hs.out_ch);
    end
    rst_n       = 1'b1;
    hs.in_valid = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (hs.in_ready !== 1'b0 || fmap_wr_en !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore in_ready=%b wr_en=%h busy=%b expected 0", hs.in_ready,
               fmap_wr_en, busy);
    end
    tick();
    hs.in_valid = 1'b0;
  endtask

  task automatic test_basic();
    do_start();
    run_fill(32'hFFFF_FFFF, -1);
    run_drain(-1, 0, -1, -1);
  endtask

  task automatic test_gapped();
    logic [31:0] vpat;
    for (int i = 0; i < 32; i++) vpat[i] = (i % 3 == 0);
    do_start();
    run_fill(vpat, -1);
    run_drain(-1, 0, -1, -1);
  endtask

  task automatic test_backpressure();
    do_start();
    run_fill(32'hFFFF_FFFF, -1);
    run_drain(3, 4, -1, -1);
  endtask

  task automatic test_ignored_start();
    do_start();
    run_fill(32'hFFFF_FFFF, 5);
    run_drain(-1, 0, 2, -1);
  endtask

  task automatic test_async_reset();
    do_start();
    run_fill(32'hFFFF_FFFF, -1);
    run_drain(-1, 0, -1, 4);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, hs.in_ready, hs.out_valid, hs.out_last} !== 5'b0 || fmap_wr_en !== '0 ||
        {fmap_wr_addr, fmap_rd_addr, hs.out_ch} !== 9'd0) begin
      failures++;
      $display("FAIL async_reset busy=%b done=%b out_valid=%b rd_addr=%0d out_ch=%0d expected 0",
               busy, done, hs.out_valid, fmap_rd_addr, hs.out_ch);
    end
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    run_fill(32'hFFFF_FFFF, -1);
    run_drain(5, 2, -1, -1);
  endtask

`ifdef FMAP_II_CTRL_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_start();
    run_fill(32'h0000_07D5, -1);
    run_drain(3, 4, -1, -1);
    checks++;
    if (stall_cnt !== 16'd7) begin
      failures++;
      $display("FAIL stall_cnt_total got=%0d expected=7", stall_cnt);
    end
    do_start();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL stall_cnt_clear got=%0d expected=0", stall_cnt);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_backpressure();
    test_ignored_start();
    test_async_reset();
`ifdef FMAP_II_CTRL_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule
